// File: rtl/cms_pix28_cfg_pkg.sv
// Shared types and default sizing for the configuration-chain sequencer.
package cms_pix28_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } cfg_state_t;

  localparam int CFG_WIDTH_DEF   = 64;
  localparam int HALF_DIV_DEF    = 4;
  localparam int LOAD_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/config_chain_ctrl.sv
// Serialises a configuration word MSB-first onto the DUT chain, captures the
// bits shifted out as readback, then strobes config_load to latch the chain.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start
//   SHIFT_LO | config_clk low, config_in presents the current MSB
//   SHIFT_HI | config_clk high; last cycle shifts data/readback
//   LOAD     | config_load high for LOAD_CYCLES cycles
//   DONE     | one-cycle done pulse, readback published, compare result
module config_chain_ctrl
  import cms_pix28_cfg_pkg::*;
#(
  parameter int CFG_WIDTH   = CFG_WIDTH_DEF,
  parameter int HALF_DIV    = HALF_DIV_DEF,
  parameter int LOAD_CYCLES = LOAD_CYCLES_DEF
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CFG_WIDTH-1:0] cfg_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic [CFG_WIDTH-1:0] cfg_rdata,
  output logic                 config_clk,
  output logic                 config_in,
  output logic                 config_load,
  input  logic                 config_out
);

  localparam int CNT_W  = $clog2(CFG_WIDTH + 1);
  // The half-period counter doubles as the LOAD counter, so size it for both.
  localparam int HCNT_W = ($clog2(HALF_DIV) > $clog2(LOAD_CYCLES)) ?
                          $clog2(HALF_DIV) : $clog2(LOAD_CYCLES);
  localparam logic [HCNT_W-1:0] HALF_M1 = HCNT_W'(HALF_DIV - 1);
  localparam logic [HCNT_W-1:0] LOAD_M1 = HCNT_W'(LOAD_CYCLES - 1);

  cfg_state_t r_state;
  cfg_state_t w_state_nxt;

  logic [HCNT_W-1:0]    r_hcnt;
  logic [HCNT_W-1:0]    w_hcnt_nxt;
  logic [CNT_W-1:0]     r_bcnt;
  logic [CFG_WIDTH-1:0] r_shift;
  logic [CFG_WIDTH-1:0] w_shift_nxt;
  logic [CFG_WIDTH-1:0] r_pend;
  logic [CFG_WIDTH-1:0] r_rback;
  logic [CFG_WIDTH-1:0] r_prev_word;
  logic                 r_prev_valid;
  logic                 r_rb_bit;
  logic                 w_cfg_out_s;
  logic                 w_hc_last;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_seq_end;

  logic                 r_busy;
  logic                 r_done;
  logic                 r_mismatch;
  logic [CFG_WIDTH-1:0] r_cfg_rdata;
  logic                 r_config_clk;
  logic                 r_config_in;
  logic                 r_config_load;

  sync_2ff u_sync_cfg_out (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .i_d     (config_out),
    .o_q     (w_cfg_out_s)
  );

  assign w_hc_last = (r_hcnt == '0);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_accept    = 1'b0;
    w_bit_end   = 1'b0;
    w_seq_end   = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
      w_hcnt_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_accept    = 1'b1;
            w_state_nxt = SHIFT_LO;
            w_hcnt_nxt  = HALF_M1;
          end
        end
        SHIFT_LO: begin
          if (w_hc_last) begin
            w_state_nxt = SHIFT_HI;
            w_hcnt_nxt  = HALF_M1;
          end else begin
            w_hcnt_nxt = r_hcnt - HCNT_W'(1);
          end
        end
        SHIFT_HI: begin
          if (w_hc_last) begin
            w_bit_end = 1'b1;
            if (r_bcnt == CNT_W'(1)) begin
              w_state_nxt = LOAD;
              w_hcnt_nxt  = LOAD_M1;
            end else begin
              w_state_nxt = SHIFT_LO;
              w_hcnt_nxt  = HALF_M1;
            end
          end else begin
            w_hcnt_nxt = r_hcnt - HCNT_W'(1);
          end
        end
        LOAD: begin
          if (w_hc_last) begin
            w_state_nxt = DONE;
            w_seq_end   = 1'b1;
          end else begin
            w_hcnt_nxt = r_hcnt - HCNT_W'(1);
          end
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept) begin
      w_shift_nxt = cfg_wdata;
    end else if (w_bit_end) begin
      w_shift_nxt = {r_shift[CFG_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_shift      <= '0;
      r_pend       <= '0;
      r_bcnt       <= '0;
      r_rback      <= '0;
      r_rb_bit     <= 1'b0;
      r_prev_word  <= '0;
      r_prev_valid <= 1'b0;
      r_cfg_rdata  <= '0;
      r_mismatch   <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      if (w_accept) begin
        r_pend     <= cfg_wdata;
        r_bcnt     <= CNT_W'(CFG_WIDTH);
        r_rback    <= '0;
        r_mismatch <= 1'b0;
      end
      // Sample just before this bit's rising edge: the chain still shows the
      // bit from the previous edge, so readback reconstructs the old contents.
      if (r_state == SHIFT_LO && w_hc_last) begin
        r_rb_bit <= w_cfg_out_s;
      end
      if (w_bit_end) begin
        r_rback <= {r_rback[CFG_WIDTH-2:0], r_rb_bit};
        r_bcnt  <= r_bcnt - CNT_W'(1);
      end
      if (w_seq_end) begin
        r_cfg_rdata <= r_rback;
        r_mismatch  <= r_prev_valid && (r_rback != r_prev_word);
      end
      if (abort) begin
        r_prev_valid <= 1'b0;
      end else if (r_state == DONE) begin
        r_prev_word  <= r_pend;
        r_prev_valid <= 1'b1;
      end
    end
  end

  // Pin/status outputs are registered from the next state so they align with it.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_config_clk  <= 1'b0;
      r_config_in   <= 1'b0;
      r_config_load <= 1'b0;
    end else begin
      r_busy        <= (w_state_nxt != IDLE);
      r_done        <= (w_state_nxt == DONE);
      r_config_clk  <= (w_state_nxt == SHIFT_HI);
      r_config_load <= (w_state_nxt == LOAD);
      r_config_in   <= ((w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI)) ?
                       w_shift_nxt[CFG_WIDTH-1] : 1'b0;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign mismatch    = r_mismatch;
  assign cfg_rdata   = r_cfg_rdata;
  assign config_clk  = r_config_clk;
  assign config_in   = r_config_in;
  assign config_load = r_config_load;

endmodule
